// File: rtl/hazard_scoreboard.sv
// Register scoreboard for the ID stage: per-register countdowns drive the issue/stall decision (HAZARD_SB_STATS_EN adds stall_count).
// Latency: issue/stall/busy are combinational from state and inputs; counters update on posedge clk.
// Backpressure: hazard or hold stalls ID; flush kills the ID instruction; hold freezes all countdowns.
module hazard_scoreboard #(
    parameter int RF_ADDRESS = 5,
    parameter int LAT_W      = 3,
    parameter int MAX_LAT    = 6
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       id_valid,
    input  logic [RF_ADDRESS-1:0]      id_rs1,
    input  logic                       id_rs1_used,
    input  logic [RF_ADDRESS-1:0]      id_rs2,
    input  logic                       id_rs2_used,
    input  logic [RF_ADDRESS-1:0]      id_rd,
    input  logic                       id_rd_we,
    input  logic [LAT_W-1:0]           id_lat,
    input  logic                       flush,
    input  logic                       hold,
    input  logic                       wb_clr,
    input  logic [RF_ADDRESS-1:0]      wb_clr_rd,
    output logic                       issue,
    output logic                       stall,
    output logic [(2**RF_ADDRESS)-1:0] busy
`ifdef HAZARD_SB_STATS_EN
    ,
    output logic [31:0]                stall_count
`endif
);

    localparam int               NUM_REGS = 2**RF_ADDRESS;
    localparam logic [LAT_W-1:0] OPEN     = '1;
    localparam logic [LAT_W-1:0] LAT_SAT  = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] cnt_q [NUM_REGS];
    logic [LAT_W-1:0] cnt_d [NUM_REGS];

    logic             hazard;
    logic             track_wr;
    logic [LAT_W-1:0] lat_fin;
    logic [LAT_W-1:0] lat_rem;

    always_comb begin
        hazard = (id_rs1_used && (cnt_q[id_rs1] != '0)) ||
                 (id_rs2_used && (cnt_q[id_rs2] != '0));
        issue  = id_valid && !hazard && !hold && !flush;
        stall  = id_valid && !flush && (hazard || hold);
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    // id_lat counts the issue cycle itself: the freshly written value ages in the
    // same cycle as every other entry, so lat=1 (ALU) never stalls the next
    // instruction and lat=2 (load) costs exactly one bubble.
    always_comb begin
        track_wr = issue && id_rd_we && (id_rd != '0) && (id_lat != '0);
        lat_fin  = (id_lat > LAT_SAT) ? LAT_SAT : id_lat;
        lat_rem  = lat_fin - LAT_W'(1);
    end

    always_comb begin
        logic [LAT_W-1:0] dec;
        for (int r = 0; r < NUM_REGS; r++) begin
            dec = '0;
            if (cnt_q[r] == OPEN) begin
                dec = OPEN;
            end else if (cnt_q[r] != '0) begin
                dec = cnt_q[r] - LAT_W'(1);
            end

            cnt_d[r] = hold ? cnt_q[r] : dec;

            if (wb_clr && (wb_clr_rd == RF_ADDRESS'(r))) begin
                cnt_d[r] = '0;
            end

            // issue implies !hold, so dec is the correctly aged old value here
            if (track_wr && (id_rd == RF_ADDRESS'(r))) begin
                if ((cnt_q[r] == OPEN) || (id_lat == OPEN)) begin
                    cnt_d[r] = OPEN;
                end else begin
                    cnt_d[r] = (dec > lat_rem) ? dec : lat_rem;
                end
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef HAZARD_SB_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall ? (stall_cnt_q + 32'd1) : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations, then random traffic
// checked every cycle against a model that tracks the absolute cycle at which each register becomes readable.
module tb_hazard_scoreboard;

    localparam int NR   = 32;
    localparam int INF  = 32'h7fffffff;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid, id_rs1_used, id_rs2_used, id_rd_we;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_clr_rd;
    logic [2:0]  id_lat;
    logic        flush, hold, wb_clr;
    logic        issue, stall;
    logic [31:0] busy;
`ifdef HAZARD_SB_STATS_EN
    logic [31:0] stall_count;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs1_used (id_rs1_used),
        .id_rs2      (id_rs2),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_rd_we    (id_rd_we),
        .id_lat      (id_lat),
        .flush       (flush),
        .hold        (hold),
        .wb_clr      (wb_clr),
        .wb_clr_rd   (wb_clr_rd),
        .issue       (issue),
        .stall       (stall),
        .busy        (busy)
`ifdef HAZARD_SB_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    int ntests = 0;
    int nfail  = 0;

    // model: ready[r] = first cycle a reader of r may issue (INF = open-ended)
    int now = 0;
    int ready [NR];
    int m_stalls = 0;
    bit e_issue, e_stall;

    function automatic void chk(string name, longint act, longint exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, now);
        end
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < NR; r++) ready[r] = 0;
        m_stalls = 0;
    endfunction

    task automatic set_in(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit we, int lat);
        id_valid    = v;
        id_rs1      = 5'(rs1);
        id_rs1_used = u1;
        id_rs2      = 5'(rs2);
        id_rs2_used = u2;
        id_rd       = 5'(rd);
        id_rd_we    = we;
        id_lat      = 3'(lat);
        flush       = 1'b0;
        hold        = 1'b0;
        wb_clr      = 1'b0;
        wb_clr_rd   = 5'd0;
    endtask

    task automatic sample();
        bit haz;
        logic [31:0] e_busy;
        #1;
        haz = (id_rs1_used && (now < ready[id_rs1])) || (id_rs2_used && (now < ready[id_rs2]));
        e_issue = id_valid && !haz && !hold && !flush;
        e_stall = id_valid && !flush && (haz || hold);
        for (int r = 0; r < NR; r++) e_busy[r] = (now < ready[r]);
        chk("issue", issue, e_issue);
        chk("stall", stall, e_stall);
        chk("busy", busy, e_busy);
`ifdef HAZARD_SB_STATS_EN
        chk("stall_count", stall_count, m_stalls);
`endif
    endtask

    task automatic adv();
        int old, l;
        if (reset_n) begin
            old = ready[id_rd];
            if (hold) begin
                for (int r = 0; r < NR; r++)
                    if (ready[r] > now && ready[r] != INF) ready[r]++;
            end
            if (wb_clr) ready[wb_clr_rd] = 0;
            if (e_issue && id_rd_we && id_rd != 0 && id_lat != 0) begin
                l = (id_lat == 7) ? INF : ((id_lat > 6) ? 6 : int'(id_lat));
                if (old == INF || l == INF) ready[id_rd] = INF;
                else ready[id_rd] = (old > now + l) ? old : now + l;
            end
            if (e_stall) m_stalls++;
        end else begin
            model_clear();
        end
        now++;
        @(negedge clk);
    endtask

    task automatic cyc();
        sample();
        adv();
    endtask

    initial begin
        model_clear();
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        // during reset: issue follows valid/hold/flush only
        set_in(1, 3, 1, 4, 1, 3, 1, 2);
        sample();
        chk("rst_issue", issue, 1);
        adv();
        hold = 1'b1;
        sample();
        chk("rst_stall_hold", stall, 1);
        adv();
        reset_n = 1'b1;

        // 1: ALU producer lat=1, dependent next cycle issues
        set_in(1, 0, 0, 0, 0, 5, 1, 1);
        cyc();
        set_in(1, 5, 1, 0, 0, 0, 0, 0);
        sample();
        chk("t1_issue", issue, 1);
        chk("t1_stall", stall, 0);
        chk("t1_busy5", busy[5], 0);
        adv();

        // 2: load-use gives exactly one bubble
        set_in(1, 0, 0, 0, 0, 6, 1, 2);
        cyc();
        set_in(1, 6, 1, 0, 0, 0, 0, 0);
        sample();
        chk("t2_stall", stall, 1);
        chk("t2_busy6", busy[6], 1);
        adv();
        sample();
        chk("t2_issue", issue, 1);
`ifdef HAZARD_SB_STATS_EN
        chk("t2_stall_count", stall_count, 1);
`endif
        adv();

        // 3: open-ended producer held until writeback clear
        set_in(1, 0, 0, 0, 0, 7, 1, 7);
        cyc();
        set_in(1, 0, 0, 7, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("t3_stall", stall, 1);
            adv();
        end
        wb_clr = 1'b1;
        wb_clr_rd = 5'd7;
        cyc();
        wb_clr = 1'b0;
        sample();
        chk("t3_issue", issue, 1);
        chk("t3_busy7", busy[7], 0);
        adv();

        // 4: x0 never tracked
        set_in(1, 0, 0, 0, 0, 0, 1, 2);
        cyc();
        set_in(1, 0, 0, 0, 0, 0, 1, 7);
        cyc();
        set_in(1, 0, 1, 0, 1, 0, 0, 0);
        sample();
        chk("t4_busy", busy, 0);
        chk("t4_issue", issue, 1);
        adv();

        // 5: hold freezes a countdown of 2 (lat=3 leaves 2 hazard cycles)
        set_in(1, 0, 0, 0, 0, 9, 1, 3);
        cyc();
        set_in(1, 9, 1, 0, 0, 0, 0, 0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t5_hold_issue", issue, 0);
            chk("t5_hold_busy9", busy[9], 1);
            adv();
        end
        hold = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("t5_post_stall", stall, 1);
            adv();
        end
        sample();
        chk("t5_issue", issue, 1);
        adv();

        // 6: flush dominates; reset clears pending entries at once
        set_in(1, 0, 0, 0, 0, 10, 1, 5);
        cyc();
        set_in(1, 10, 1, 0, 0, 0, 0, 0);
        flush = 1'b1;
        sample();
        chk("t6_flush_issue", issue, 0);
        chk("t6_flush_stall", stall, 0);
        adv();
        set_in(1, 0, 0, 0, 0, 11, 1, 7);
        cyc();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("t6_busy_set", (busy != 0), 1);
        adv();
        reset_n = 1'b0;
        model_clear();
        sample();
        chk("t6_rst_busy", busy, 0);
        adv();
        reset_n = 1'b1;

        // random traffic on a small register window to provoke hazards
        for (int n = 0; n < 4000; n++) begin
            set_in($urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   ($urandom_range(0, 11) == 0) ? 7 : $urandom_range(0, 6));
            flush     = ($urandom_range(0, 9) == 0);
            hold      = ($urandom_range(0, 7) == 0);
            wb_clr    = ($urandom_range(0, 3) == 0);
            wb_clr_rd = 5'($urandom_range(0, 7));
            if (!reset_n) begin
                reset_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                model_clear();
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
